// File: rtl/uart_register_peripheral_pkg.sv
// Shared register map, STATUS layout and FSM state types for the UART peripheral.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_register_peripheral_pkg;

  // Register offsets from BASE_INDEX; also used by the core's software and the bench.
  localparam logic [1:0] REG_UART_STATUS = 2'd0;
  localparam logic [1:0] REG_UART_TX     = 2'd1;
  localparam logic [1:0] REG_UART_RX     = 2'd2;
  localparam logic [1:0] REG_UART_CTRL   = 2'd3;

  // STATUS bit positions.
  localparam int STAT_TX_BUSY     = 0;
  localparam int STAT_RX_READY    = 1;
  localparam int STAT_RX_OVERRUN  = 2;
  localparam int STAT_RX_FRAME_ERR = 3;
  localparam int STAT_RX_FULL     = 4;

  // CTRL write bits (write 1 to clear the matching sticky flag).
  localparam int CTRL_CLR_OVERRUN   = 0;
  localparam int CTRL_CLR_FRAME_ERR = 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // STATUS register image, MSB first so it packs straight onto the 16-bit read bus.
  typedef struct packed {
    logic [10:0] rsvd;
    logic        rx_full;
    logic        rx_frame_err;
    logic        rx_overrun;
    logic        rx_ready;
    logic        tx_busy;
  } status_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head output.
// Latency: a push is visible on head_dat/empty the cycle after the push edge.
// Backpressure: push into a full FIFO is dropped unless a pop happens in the same cycle.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset (empties the FIFO)
//   push_vld, push_dat    write request and data
//   pop_vld               remove head (ignored when empty)
//   full, empty, head_dat occupancy flags and current head entry
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_dat
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // One extra pointer bit distinguishes full from empty when the index bits match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  // Pop is evaluated first, so a full FIFO still accepts a push that coincides with a pop.
  assign pop_ok  = pop_vld && !empty;
  assign push_ok = push_vld && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/uart_register_peripheral.sv
// Register-mapped 8N1 UART: TX shifter, RX deserialiser and RX FIFO behind a 4-register window.
// Latency: read data registered, valid the cycle after the read access; TX starts the cycle after the write.
// Backpressure: TX writes while busy are dropped; RX bytes arriving with the FIFO full are dropped (overrun).
//
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   register_index                      7-bit register select from the core
//   register_read / register_write      access strobes (read is also high during writes)
//   register_write_value                16-bit write data
//   register_read_value                 16-bit registered read data, holds between reads
//   uart_tx                             serial out, idle high
//   uart_rx                             serial in, asynchronous to clk
module uart_register_peripheral
  import uart_register_peripheral_pkg::*;
#(
  parameter int BAUD_DIVISOR  = 217,
  parameter int RX_FIFO_DEPTH = 8,
  parameter int BASE_INDEX    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  register_index,
  input  logic        register_read,
  input  logic        register_write,
  input  logic [15:0] register_write_value,
  output logic [15:0] register_read_value,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int CNT_W = $clog2(BAUD_DIVISOR);
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(BAUD_DIVISOR - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(BAUD_DIVISOR / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Register decode
  // ---------------------------------------------------------------------------
  logic [7:0] rel_index;
  logic       in_window;
  logic [1:0] reg_off;
  logic       read_acc;
  logic       tx_wr;
  logic       ctrl_wr;
  logic       rx_pop;
  logic       unused_wdata;

  // 8-bit subtraction: indices below BASE_INDEX wrap to >=129 and fall outside the window.
  assign rel_index = {1'b0, register_index} - 8'(BASE_INDEX);
  assign in_window = (rel_index < 8'd4);
  assign reg_off   = rel_index[1:0];
  assign read_acc  = register_read && !register_write;
  assign tx_wr     = register_write && in_window && (reg_off == REG_UART_TX);
  assign ctrl_wr   = register_write && in_window && (reg_off == REG_UART_CTRL);
  assign rx_pop    = read_acc && in_window && (reg_off == REG_UART_RX);

  assign unused_wdata = ^register_write_value[15:8];

  // ---------------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------------
  tx_state_t        tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shreg;
  logic             tx_busy;

  assign tx_busy = (tx_state != TX_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_wr) begin
            tx_state <= TX_START;
            tx_cnt   <= BIT_RELOAD;
            tx_shreg <= register_write_value[7:0];
            uart_tx  <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == '0) begin
            tx_state <= TX_DATA;
            tx_cnt   <= BIT_RELOAD;
            tx_bit   <= '0;
            uart_tx  <= tx_shreg[0];
          end else begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end
        end
        TX_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= BIT_RELOAD;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              uart_tx  <= 1'b1;
            end else begin
              // Bit 0 of the shifted register goes out next, i.e. current bit 1.
              tx_bit   <= tx_bit + 3'd1;
              tx_shreg <= {1'b0, tx_shreg[7:1]};
              uart_tx  <= tx_shreg[1];
            end
          end else begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end
        end
        TX_STOP: begin
          if (tx_cnt == '0) begin
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          uart_tx  <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX synchroniser and FSM
  // ---------------------------------------------------------------------------
  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic             rx_fall;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shreg;
  logic             rx_push_vld;
  logic [7:0]       rx_push_dat;
  logic             rx_ferr_set;

  // Synchroniser flops reset to the idle line level so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev && !rx_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state    <= RX_IDLE;
      rx_cnt      <= '0;
      rx_bit      <= '0;
      rx_shreg    <= '0;
      rx_push_vld <= 1'b0;
      rx_push_dat <= '0;
      rx_ferr_set <= 1'b0;
    end else begin
      rx_push_vld <= 1'b0;
      rx_ferr_set <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state <= RX_START;
            rx_cnt   <= HALF_RELOAD;
          end
        end
        RX_START: begin
          // Mid-start-bit check: a line back at 1 was a glitch, not a frame.
          if (rx_cnt == '0) begin
            if (!rx_sync) begin
              rx_state <= RX_DATA;
              rx_cnt   <= BIT_RELOAD;
              rx_bit   <= '0;
            end else begin
              rx_state <= RX_IDLE;
            end
          end else begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt == '0) begin
            rx_shreg <= {rx_sync, rx_shreg[7:1]};
            rx_cnt   <= BIT_RELOAD;
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end
        end
        RX_STOP: begin
          if (rx_cnt == '0) begin
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              rx_push_vld <= 1'b1;
              rx_push_dat <= rx_shreg;
            end else begin
              rx_ferr_set <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX FIFO and sticky flags
  // ---------------------------------------------------------------------------
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic       overrun_set;
  logic       rx_overrun;
  logic       rx_frame_err;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (rx_push_vld),
    .push_dat (rx_push_dat),
    .pop_vld  (rx_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (fifo_head)
  );

  // A same-cycle pop frees a slot, so only an unmatched push into a full FIFO overruns.
  assign overrun_set = rx_push_vld && fifo_full && !rx_pop;

  // Set has priority over a CTRL clear landing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (overrun_set) begin
        rx_overrun <= 1'b1;
      end else if (ctrl_wr && register_write_value[CTRL_CLR_OVERRUN]) begin
        rx_overrun <= 1'b0;
      end
      if (rx_ferr_set) begin
        rx_frame_err <= 1'b1;
      end else if (ctrl_wr && register_write_value[CTRL_CLR_FRAME_ERR]) begin
        rx_frame_err <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read data
  // ---------------------------------------------------------------------------
  status_t status;

  always_comb begin
    status              = '0;
    status.tx_busy      = tx_busy;
    status.rx_ready     = !fifo_empty;
    status.rx_overrun   = rx_overrun;
    status.rx_frame_err = rx_frame_err;
    status.rx_full      = fifo_full;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      register_read_value <= '0;
    end else if (read_acc) begin
      if (!in_window) begin
        register_read_value <= '0;
      end else begin
        case (reg_off)
          REG_UART_STATUS: register_read_value <= status;
          REG_UART_RX:     register_read_value <= fifo_empty ? 16'h0000 : {8'h00, fifo_head};
          default:         register_read_value <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_register_peripheral.sv
module tb_uart_register_peripheral;
  import uart_register_peripheral_pkg::*;

  localparam int BAUD  = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  register_index = '0;
  logic        register_read = 1'b0;
  logic        register_write = 1'b0;
  logic [15:0] register_write_value = '0;
  logic [15:0] register_read_value;
  logic        uart_tx;
  logic        uart_rx = 1'b1;

  uart_register_peripheral #(
    .BAUD_DIVISOR  (BAUD),
    .RX_FIFO_DEPTH (DEPTH),
    .BASE_INDEX    (0)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .register_index       (register_index),
    .register_read        (register_read),
    .register_write       (register_write),
    .register_write_value (register_write_value),
    .register_read_value  (register_read_value),
    .uart_tx              (uart_tx),
    .uart_rx              (uart_rx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [15:0] v;
    logic [6:0]  idx;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tx_q[$];
  bit         tx_mon_en = 1'b1;
  bit         tx_mon_active = 1'b0;

  // Reference model: FIFO as a bounded queue, sticky flags, TX busy window in clock edges.
  logic [7:0] m_fifo[$];
  bit         m_ovr = 1'b0;
  bit         m_ferr = 1'b0;
  int         tx_end = 0;

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // STATUS as seen by a read captured at clock edge pe. A frame is 10 bits of BAUD
  // cycles, busy from the edge after the accepting write through the last stop cycle.
  function automatic logic [15:0] m_status(int pe);
    logic [15:0] s;
    s = '0;
    s[STAT_TX_BUSY]      = (pe <= tx_end);
    s[STAT_RX_READY]     = (m_fifo.size() != 0);
    s[STAT_RX_OVERRUN]   = m_ovr;
    s[STAT_RX_FRAME_ERR] = m_ferr;
    s[STAT_RX_FULL]      = (m_fifo.size() == DEPTH);
    return s;
  endfunction

  function automatic void m_rx_frame(logic [7:0] b, bit stop_ok);
    if (!stop_ok) m_ferr = 1'b1;
    else if (m_fifo.size() == DEPTH) m_ovr = 1'b1;
    else m_fifo.push_back(b);
  endfunction

  function automatic void m_reset();
    m_fifo.delete();
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    tx_end = 0;
  endfunction

  // One read access per call; consecutive calls are back-to-back cycles.
  task automatic rd(logic [6:0] idx);
    exp_t e;
    int   pe;
    @(negedge clk);
    pe    = cyc + 1;
    e.idx = idx;
    if (idx > 7'd3) e.v = 16'h0000;
    else if (idx[1:0] == REG_UART_STATUS) e.v = m_status(pe);
    else if (idx[1:0] == REG_UART_RX) e.v = (m_fifo.size() == 0) ? 16'h0000 : {8'h00, m_fifo.pop_front()};
    else e.v = 16'h0000;
    register_index = idx;
    register_read  = 1'b1;
    register_write = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic wr(logic [6:0] idx, logic [15:0] val);
    int pe;
    @(negedge clk);
    pe = cyc + 1;
    if (idx == {5'd0, REG_UART_TX}) begin
      if (pe > tx_end) begin
        tx_q.push_back(val[7:0]);
        tx_end = pe + 10 * BAUD;
      end
    end else if (idx == {5'd0, REG_UART_CTRL}) begin
      if (val[CTRL_CLR_OVERRUN])   m_ovr  = 1'b0;
      if (val[CTRL_CLR_FRAME_ERR]) m_ferr = 1'b0;
    end
    register_index       = idx;
    register_read        = 1'b1;
    register_write       = 1'b1;
    register_write_value = val;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    register_read  = 1'b0;
    register_write = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(logic [7:0] b, bit stop_ok);
    logic [9:0] bits;
    bus_idle();
    bits = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      repeat (BAUD) @(negedge clk);
    end
    uart_rx = 1'b1;
    idle(6);
    m_rx_frame(b, stop_ok);
  endtask

  // Read-data monitor: after every edge, a read access must show the next expected value,
  // any other cycle must still show the previous one.
  initial begin
    logic [15:0] last;
    logic        acc;
    logic        rs;
    exp_t        e;
    last = '0;
    forever begin
      @(posedge clk);
      acc = register_read && !register_write;
      rs  = reset;
      #1;
      if (rs) begin
        last = '0;
        check("rdval_reset", register_read_value, 16'h0000);
      end else if (acc) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected: got %h want none", register_read_value);
        end else begin
          e    = exp_q.pop_front();
          last = e.v;
          check($sformatf("rd_idx%0d", e.idx), register_read_value, e.v);
        end
      end else begin
        check("rdval_hold", register_read_value, last);
      end
    end
  end

  // TX monitor: on each falling edge of uart_tx, sample every bit at mid-bit and
  // compare the frame against the next byte the bench expects to see transmitted.
  initial begin
    logic       prev;
    logic [9:0] bits;
    logic [7:0] want;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_mon_en && prev === 1'b1 && uart_tx === 1'b0) begin
        tx_mon_active = 1'b1;
        repeat (BAUD / 2 - 1) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
          bits[k] = uart_tx;
          if (k < 9) repeat (BAUD) @(negedge clk);
        end
        if (tx_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexpected_frame: got %h want none", bits[8:1]);
        end else begin
          want = tx_q.pop_front();
          check("tx_start", {15'd0, bits[0]}, 16'h0000);
          check("tx_data", {8'd0, bits[8:1]}, {8'd0, want});
          check("tx_stop", {15'd0, bits[9]}, 16'h0001);
        end
        tx_mon_active = 1'b0;
      end
      prev = uart_tx;
    end
  end

  initial begin
    int wpe;
    int n;
    logic [6:0] idx;

    // Reset state
    idle(3);
    reset = 1'b0;
    m_reset();
    idle(2);
    check("tx_idle_after_reset", {15'd0, uart_tx}, 16'h0001);
    rd({5'd0, REG_UART_STATUS});
    rd({5'd0, REG_UART_RX});
    bus_idle();

    // TX frame 0xA5, busy in frame, a mid-frame write dropped, exact busy end
    wr({5'd0, REG_UART_TX}, 16'h00A5);
    wpe = cyc + 1;
    rd({5'd0, REG_UART_STATUS});
    bus_idle();
    idle(5);
    wr({5'd0, REG_UART_TX}, 16'h003C);
    bus_idle();
    while (cyc + 1 < wpe + 10 * BAUD) @(negedge clk);
    rd({5'd0, REG_UART_STATUS});
    rd({5'd0, REG_UART_STATUS});
    bus_idle();
    idle(10);

    // Single RX frame
    send_rx(8'h3C, 1'b1);
    rd({5'd0, REG_UART_STATUS});
    rd({5'd0, REG_UART_RX});
    rd({5'd0, REG_UART_STATUS});
    bus_idle();

    // Overfill the FIFO, drain back-to-back, clear overrun
    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
    rd({5'd0, REG_UART_STATUS});
    for (int i = 0; i < 5; i++) rd({5'd0, REG_UART_RX});
    rd({5'd0, REG_UART_STATUS});
    wr({5'd0, REG_UART_CTRL}, 16'h0001);
    rd({5'd0, REG_UART_STATUS});
    bus_idle();

    // Framing error and its clear
    send_rx(8'h77, 1'b0);
    rd({5'd0, REG_UART_STATUS});
    rd({5'd0, REG_UART_RX});
    wr({5'd0, REG_UART_CTRL}, 16'h0002);
    rd({5'd0, REG_UART_STATUS});
    bus_idle();

    // One-cycle glitch, out-of-window read and write
    @(negedge clk) uart_rx = 1'b0;
    @(negedge clk) uart_rx = 1'b1;
    idle(3 * BAUD);
    rd({5'd0, REG_UART_STATUS});
    rd(7'h05);
    wr(7'h05, 16'hFFFF);
    rd({5'd0, REG_UART_STATUS});
    bus_idle();

    // Randomized mix
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 6))
        0, 1: send_rx(8'($urandom_range(0, 255)), ($urandom_range(0, 5) != 0));
        2: begin
          n = $urandom_range(1, 3);
          for (int j = 0; j < n; j++) rd({5'd0, REG_UART_RX});
          bus_idle();
        end
        3: begin
          rd({5'd0, REG_UART_STATUS});
          bus_idle();
        end
        4: begin
          wr({5'd0, REG_UART_CTRL}, 16'($urandom_range(0, 3)));
          bus_idle();
        end
        5: begin
          idx = 7'($urandom_range(0, 127));
          if (idx == {5'd0, REG_UART_TX} || idx == {5'd0, REG_UART_CTRL}) idx = 7'h04;
          wr(idx, 16'($urandom_range(0, 65535)));
          rd(7'($urandom_range(4, 127)));
          bus_idle();
        end
        default: begin
          wr({5'd0, REG_UART_TX}, 16'($urandom_range(0, 65535)));
          rd({5'd0, REG_UART_STATUS});
          bus_idle();
          idle($urandom_range(0, 12 * BAUD));
        end
      endcase
    end
    idle(12 * BAUD);
    rd({5'd0, REG_UART_STATUS});
    bus_idle();

    // Reset in the middle of a TX frame and an RX frame, with data in the FIFO
    send_rx(8'h5A, 1'b1);
    idle(12 * BAUD);
    tx_mon_en = 1'b0;
    wr({5'd0, REG_UART_TX}, 16'h0081);
    bus_idle();
    uart_rx = 1'b0;
    idle(BAUD * 2);
    uart_rx = 1'b1;
    idle(BAUD);
    reset   = 1'b1;
    uart_rx = 1'b1;
    @(posedge clk);
    #1;
    check("tx_after_reset_edge", {15'd0, uart_tx}, 16'h0001);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    tx_q.delete();
    idle(12 * BAUD);
    check("tx_idle_post_reset", {15'd0, uart_tx}, 16'h0001);
    tx_mon_en = 1'b1;
    rd({5'd0, REG_UART_STATUS});
    rd({5'd0, REG_UART_RX});
    bus_idle();

    // Drain, bounded
    for (int i = 0; i < 200 && (exp_q.size() != 0 || tx_q.size() != 0 || tx_mon_active); i++)
      @(negedge clk);
    if (exp_q.size() != 0 || tx_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d reads and %0d tx frames pending want 0", exp_q.size(), tx_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
